vram_scheduler: RTL and testbench

//  Time-slot scheduler for the single-port synchronous video RAM. It shares the RAM between
//  two users: the 640x480 scan-out path, which is fed by the VGA timing generator's

---
 rtl/vram_scheduler.sv | 126 ++++++++++++
 tb/tb_vram_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_scheduler.sv
// Video RAM time-slot scheduler: interleaves fixed scan-out fetches with a
// CPU request/ack port on a single-port synchronous RAM, and drives the
// current pixel out of the fetched word.
module vram_scheduler #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 17,
  parameter int WORDS_PER_LINE = 160,
  parameter int V_ACTIVE       = 480
) (
  input  logic              clock25Mhz,
  input  logic              reset,
  input  logic              isActive,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWdata,
  output logic              cpuAck,
  output logic [DATA_W-1:0] cpuRdata,
  output logic              ramEn,
  output logic              ramWe,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramWdata,
  input  logic [DATA_W-1:0] ramRdata,
  output logic [DATA_W/4-1:0] pixel
);

  localparam int BPP = DATA_W / 4;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

  state_t              state_q, state_d;
  logic                cpu_rd_q, cpu_rd_d;       // in-flight CPU access is a read
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   pix_word_q, pix_word_d;
  logic                vid_pend_q, vid_pend_d;   // video read data arrives this cycle

  logic                vid_slot;
  logic [7:0]          vid_word;
  logic [ADDR_W-1:0]   vid_addr;
  logic                cpu_issue;
  logic [3:0][BPP-1:0] pix_lanes;

  // Video slot decode: fetch word n two pixels ahead of pixel 4n. (x+2)>>2 in
  // 10-bit wrap is x[9:2] plus the carry out of x[1:0]+2, i.e. x[1].
  always_comb begin
    vid_slot = (x[1:0] == 2'd2) && ((x == 10'd1022) || (x < 10'd636))
               && (y < 9'(V_ACTIVE));
    vid_word = x[9:2] + {7'd0, x[1]};
    vid_addr = ADDR_W'(y) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(vid_word);
  end

  // CPU FSM state register
  always_ff @(posedge clock25Mhz or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // CPU FSM next state: a request waits in IDLE while a video slot owns the RAM
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cpuReq && !vid_slot) state_d = S_ACCESS;
      S_ACCESS: state_d = S_ACK;
      S_ACK:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // CPU FSM outputs
  always_comb begin
    cpu_issue = (state_q == S_IDLE) && cpuReq && !vid_slot;
    cpuAck    = (state_q == S_ACK);
  end

  // RAM port mux: video has priority; everything is held off while in reset
  always_comb begin
    ramEn    = 1'b0;
    ramWe    = 1'b0;
    ramAddr  = '0;
    ramWdata = cpuWdata;
    if (reset) begin
      if (vid_slot) begin
        ramEn   = 1'b1;
        ramAddr = vid_addr;
      end else if (cpu_issue) begin
        ramEn   = 1'b1;
        ramWe   = cpuWe;
        ramAddr = cpuAddr;
      end
    end
  end

  // Datapath next-state: read-data capture for CPU and video
  always_comb begin
    cpu_rd_d    = cpu_issue ? !cpuWe : cpu_rd_q;
    cpu_rdata_d = cpu_rdata_q;
    if ((state_q == S_ACCESS) && cpu_rd_q) cpu_rdata_d = ramRdata;
    vid_pend_d  = vid_slot;
    pix_word_d  = vid_pend_q ? ramRdata : pix_word_q;
  end

  // Datapath registers
  always_ff @(posedge clock25Mhz or negedge reset) begin
    if (!reset) begin
      cpu_rd_q    <= 1'b0;
      cpu_rdata_q <= '0;
      vid_pend_q  <= 1'b0;
      pix_word_q  <= '0;
    end else begin
      cpu_rd_q    <= cpu_rd_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_pend_q  <= vid_pend_d;
      pix_word_q  <= pix_word_d;
    end
  end

  // Pixel select: lane 0 (LSBs) is the leftmost pixel of the word
  always_comb begin
    pix_lanes = pix_word_q;
    cpuRdata  = cpu_rdata_q;
    pixel     = isActive ? pix_lanes[x[1:0]] : '0;
  end

endmodule

// File: tb/tb_vram_scheduler.sv
// Scoreboard bench for vram_scheduler: stimulus pushes expected RAM issues,
// CPU acks and pixels; a negedge monitor pops and compares them.
module tb_vram_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        isActive;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        cpuReq, cpuWe;
  logic [16:0] cpuAddr;
  logic [15:0] cpuWdata;
  logic        cpuAck;
  logic [15:0] cpuRdata;
  logic        ramEn, ramWe;
  logic [16:0] ramAddr;
  logic [15:0] ramWdata;
  logic [15:0] ramRdata;
  logic [3:0]  pixel;

  vram_scheduler dut (
    .clock25Mhz(clk), .reset(reset), .isActive(isActive), .x(x), .y(y),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
    .cpuAck(cpuAck), .cpuRdata(cpuRdata), .ramEn(ramEn), .ramWe(ramWe),
    .ramAddr(ramAddr), .ramWdata(ramWdata), .ramRdata(ramRdata), .pixel(pixel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; bit we; int addr; int wd;} ram_t;
  typedef struct {int c; int rd;} ack_t;
  typedef struct {int c; int v;} pix_t;
  ram_t ram_q[$];
  ack_t ack_q[$];
  pix_t pix_q[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic exp_ram(input bit we, input int addr, input int wd);
    ram_q.push_back('{cyc, we, addr, wd});
  endtask
  task automatic exp_ack(input int rd);
    ack_q.push_back('{cyc + 2, rd});
  endtask
  task automatic exp_pix(input int v);
    pix_q.push_back('{cyc, v});
  endtask

  task automatic drive(input int xv, input int yv, input bit act, input int rd);
    x = 10'(xv); y = 9'(yv); isActive = act; ramRdata = 16'(rd);
    @(posedge clk); #1;
  endtask

  // Monitor: pop an expectation whenever the DUT presents an output
  always @(negedge clk) begin
    ram_t r; ack_t a; pix_t p;
    if (ramEn !== 1'b0) begin
      if (ram_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL ram_unexpected @cyc %0d: got addr %0h expected no issue", cyc, ramAddr);
      end else begin
        r = ram_q.pop_front();
        chk("ram_cycle", cyc, r.c);
        chk("ram_we", {31'd0, ramWe}, {31'd0, r.we});
        chk("ram_addr", {15'd0, ramAddr}, r.addr);
        if (r.we) chk("ram_wdata", {16'd0, ramWdata}, r.wd);
      end
    end
    if (cpuAck !== 1'b0) begin
      if (ack_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL ack_unexpected @cyc %0d: got ack expected none", cyc);
      end else begin
        a = ack_q.pop_front();
        chk("ack_cycle", cyc, a.c);
        chk("ack_rdata", {16'd0, cpuRdata}, a.rd);
      end
    end
    if (isActive) begin
      if (pix_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL pix_unexpected @cyc %0d: got %0h expected no entry", cyc, pixel);
      end else begin
        p = pix_q.pop_front();
        chk("pix_cycle", cyc, p.c);
        chk("pixel", {28'd0, pixel}, p.v);
      end
    end else begin
      chk("pixel_blank", {28'd0, pixel}, 0);
    end
  end

  initial begin
    reset = 1'b1;
    isActive = 0; x = 0; y = 9'd500; ramRdata = 0;
    cpuReq = 0; cpuWe = 0; cpuAddr = 0; cpuWdata = 0;
    #1 reset = 1'b0;
    // request pending while in reset must not reach the RAM
    cpuReq = 1; cpuAddr = 17'd3;
    #1;
    chk("rst_ack", {31'd0, cpuAck}, 0);
    chk("rst_rdata", {16'd0, cpuRdata}, 0);
    chk("rst_ramEn", {31'd0, ramEn}, 0);
    chk("rst_ramWe", {31'd0, ramWe}, 0);
    chk("rst_ramAddr", {15'd0, ramAddr}, 0);
    chk("rst_pixel", {28'd0, pixel}, 0);
    drive(0, 500, 0, 0);
    drive(0, 500, 0, 0);
    cpuReq = 0; reset = 1'b1;
    drive(0, 500, 0, 0);
    drive(1, 500, 0, 0);

    // slot addressing and blanking boundaries
    exp_ram(0, 1602, 0);  drive(6, 10, 0, 0);
    drive(6, 480, 0, 0);
    drive(638, 10, 0, 0);
    exp_ram(0, 1759, 0);  drive(634, 10, 0, 0);
    exp_ram(0, 76641, 0); drive(2, 479, 0, 0);
    drive(1022, 480, 0, 0);
    drive(1021, 0, 0, 0);

    // line start prefetch at x=1022 and pixel ordering
    exp_ram(0, 0, 0); drive(1022, 0, 0, 0);
    drive(1023, 0, 0, 'hABCD);
    exp_pix('hD); drive(0, 0, 1, 0);
    exp_pix('hC); drive(1, 0, 1, 0);
    exp_pix('hB); exp_ram(0, 1, 0); drive(2, 0, 1, 0);
    exp_pix('hA); drive(3, 0, 1, 'h4321);
    exp_pix('h1); drive(4, 0, 1, 0);
    exp_pix('h2); drive(5, 0, 1, 0);
    exp_pix('h3); exp_ram(0, 2, 0); drive(6, 0, 1, 0);
    exp_pix('h4); drive(7, 0, 1, 'h0F0F);
    drive(8, 0, 0, 0);

    // CPU write raised in a slot cycle is deferred one cycle
    drive(1, 20, 0, 0);
    cpuReq = 1; cpuWe = 1; cpuAddr = 17'd5; cpuWdata = 16'h1234;
    exp_ram(0, 3201, 0); drive(2, 20, 0, 0);
    exp_ram(1, 5, 'h1234); exp_ack(0); drive(3, 20, 0, 0);
    drive(4, 20, 0, 0);
    drive(5, 20, 0, 0);
    cpuReq = 0;
    exp_ram(0, 3202, 0); drive(6, 20, 0, 0);
    drive(7, 20, 0, 0);

    // CPU read issued immediately; following video slot untouched
    cpuReq = 1; cpuWe = 0; cpuAddr = 17'd7;
    exp_ram(0, 7, 0); exp_ack('h55AA); drive(3, 20, 0, 0);
    drive(4, 20, 0, 'h55AA);
    drive(5, 20, 0, 0);
    cpuReq = 0;
    exp_ram(0, 3202, 0); drive(6, 20, 0, 0);
    drive(7, 20, 0, 'h1357);
    exp_pix('h7); drive(8, 20, 1, 0);
    exp_pix('h5); drive(9, 20, 1, 0);

    // back-to-back reads with cpuReq held across ACK
    cpuReq = 1; cpuWe = 0; cpuAddr = 17'd9;
    exp_ram(0, 9, 0); exp_ack('h1111); drive(12, 20, 0, 0);
    drive(13, 20, 0, 'h1111);
    exp_ram(0, 3204, 0); drive(14, 20, 0, 0);
    exp_ram(0, 9, 0); exp_ack('h2222); drive(15, 20, 0, 'h2468);
    drive(16, 20, 0, 'h2222);
    drive(17, 20, 0, 0);
    cpuReq = 0;
    exp_ram(0, 3205, 0); drive(18, 20, 0, 0);
    drive(19, 20, 0, 'h9999);

    // reset in the middle of a CPU read
    cpuReq = 1; cpuWe = 0; cpuAddr = 17'd3;
    exp_ram(0, 3, 0); drive(8, 500, 0, 0);
    reset = 1'b0;
    #1;
    chk("midrst_ack", {31'd0, cpuAck}, 0);
    chk("midrst_ramEn", {31'd0, ramEn}, 0);
    chk("midrst_rdata", {16'd0, cpuRdata}, 0);
    exp_pix(0); drive(9, 500, 1, 'hDEAD);
    exp_pix(0); drive(10, 500, 1, 'hDEAD);
    cpuReq = 0; reset = 1'b1;
    drive(11, 500, 0, 0);
    drive(12, 500, 0, 0);
    drive(13, 500, 0, 0);
    // FSM back in IDLE: immediate issue, ack two cycles later
    cpuReq = 1; cpuAddr = 17'd4;
    exp_ram(0, 4, 0); exp_ack('h7777); drive(16, 500, 0, 0);
    drive(17, 500, 0, 'h7777);
    drive(18, 500, 0, 0);
    cpuReq = 0;
    drive(19, 500, 0, 0);
    drive(20, 500, 0, 0);

    chk("ram_q_drained", ram_q.size(), 0);
    chk("ack_q_drained", ack_q.size(), 0);
    chk("pix_q_drained", pix_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
